// File: rtl/ldst_sequencer.sv
// ldst_sequencer: issues one load or store per command handshake to the
// somador / registrador / memoria datapath. It holds the adder operands
// and register indices for the whole command and pulses the register-file
// or memory write enable in the right cycle. Address faults from subtract
// underflow or out-of-range results end the command with err and no write.
module ldst_sequencer #(
  parameter int READ_LAT  = 1,
  parameter int MEM_DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [4:0] cmd_a,
  input  logic [4:0] cmd_b,
  input  logic       cmd_sub,
  input  logic [4:0] cmd_reg,
  output logic [4:0] add_a,
  output logic [4:0] add_b,
  output logic       add_sinal,
  input  logic [5:0] add_res,
  output logic [4:0] reg_ra,
  output logic [4:0] reg_rw,
  output logic       reg_we,
  output logic       mem_we,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_MEM_WR  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_REG_WR  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Depth compared on 7 bits so MEM_DEPTH = 64 stays representable.
  localparam logic [6:0] DEPTH_LIM = 7'(MEM_DEPTH);
  // Last value of the read-wait counter: RD_WAIT lasts READ_LAT cycles.
  localparam logic [2:0] WAIT_LAST = 3'(READ_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic       op_q;
  logic [4:0] a_q;
  logic [4:0] b_q;
  logic       sub_q;
  logic [4:0] reg_q;
  logic       err_q;
  logic [2:0] wait_cnt;
  logic       accept;
  logic       wait_last;

  // Address fault: a subtract that would go negative (the 6-bit adder result
  // wraps and could otherwise look legal), or a result beyond the memory.
  function automatic logic addr_fault(input logic       sub,
                                      input logic [4:0] a,
                                      input logic [4:0] b,
                                      input logic [5:0] res);
    logic under;
    logic range;
    under = sub && (a < b);
    range = ({1'b0, res} >= DEPTH_LIM);
    return under || range;
  endfunction

  assign accept    = cmd_valid && (state == S_IDLE);
  assign wait_last = (wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (addr_fault(sub_q, a_q, b_q, add_res)) begin
          state_nxt = S_DONE;
        end else if (op_q) begin
          state_nxt = S_MEM_WR;
        end else begin
          state_nxt = S_RD_WAIT;
        end
      end
      S_MEM_WR:  state_nxt = S_DONE;
      S_RD_WAIT: begin
        if (wait_last) begin
          state_nxt = S_REG_WR;
        end
      end
      S_REG_WR:  state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Command capture at the handshake; values are held until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q  <= 1'b0;
      a_q   <= 5'd0;
      b_q   <= 5'd0;
      sub_q <= 1'b0;
      reg_q <= 5'd0;
    end else if (accept) begin
      op_q  <= cmd_op;
      a_q   <= cmd_a;
      b_q   <= cmd_b;
      sub_q <= cmd_sub;
      reg_q <= cmd_reg;
    end
  end

  // Read-wait counter and the fault flag sampled at the end of ADDR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      if (state == S_RD_WAIT) begin
        wait_cnt <= wait_cnt + 3'd1;
      end else begin
        wait_cnt <= 3'd0;
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (state == S_ADDR) begin
        err_q <= addr_fault(sub_q, a_q, b_q, add_res);
      end
    end
  end

  // Strobes decoded from the state; write enables are mutually exclusive.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    mem_we    = (state == S_MEM_WR);
    reg_we    = (state == S_REG_WR);
    done      = (state == S_DONE);
    err       = (state == S_DONE) && err_q;
  end

  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_sinal = sub_q;
  assign reg_ra    = reg_q;
  assign reg_rw    = reg_q;

endmodule

// File: tb/tb_ldst_sequencer.sv
// Bench for ldst_sequencer: two instances (READ_LAT=1/MEM_DEPTH=64 and
// READ_LAT=3/MEM_DEPTH=40), each wired to a small behavioural adder,
// register file and memory, driven with directed load/store commands.
module tb_ldst_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cmd_valid = 2'b00;
  logic       cmd_op = 1'b0;
  logic [4:0] cmd_a = 5'd0;
  logic [4:0] cmd_b = 5'd0;
  logic       cmd_sub = 1'b0;
  logic [4:0] cmd_reg = 5'd0;

  logic [1:0] cmd_ready_v;
  logic [1:0] add_sinal_v;
  logic [1:0] reg_we_v;
  logic [1:0] mem_we_v;
  logic [1:0] done_v;
  logic [1:0] err_v;
  logic [4:0] add_a_v  [2];
  logic [4:0] add_b_v  [2];
  logic [4:0] reg_ra_v [2];
  logic [4:0] reg_rw_v [2];
  logic [5:0] add_res_v[2];

  logic [7:0] rf0  [32] = '{0: 8'd32, 5: 8'd77, default: 8'd0};
  logic [7:0] mem0 [64] = '{default: 8'd0};
  logic [7:0] rf1  [32] = '{5: 8'd55, 14: 8'h11, default: 8'd0};
  logic [7:0] mem1 [64] = '{default: 8'd0};

  int n_checks = 0;
  int n_errors = 0;

  int first_mem, cnt_mem, first_reg, cnt_reg, done_cyc, err_val, busy;
  int ra_at_we, rw_at_we, res_at_we;

  always #5 clk = ~clk;

  ldst_sequencer #(.READ_LAT(1), .MEM_DEPTH(64)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready_v[0]),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sub(cmd_sub), .cmd_reg(cmd_reg),
    .add_a(add_a_v[0]), .add_b(add_b_v[0]), .add_sinal(add_sinal_v[0]), .add_res(add_res_v[0]),
    .reg_ra(reg_ra_v[0]), .reg_rw(reg_rw_v[0]), .reg_we(reg_we_v[0]), .mem_we(mem_we_v[0]),
    .done(done_v[0]), .err(err_v[0])
  );

  ldst_sequencer #(.READ_LAT(3), .MEM_DEPTH(40)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready_v[1]),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sub(cmd_sub), .cmd_reg(cmd_reg),
    .add_a(add_a_v[1]), .add_b(add_b_v[1]), .add_sinal(add_sinal_v[1]), .add_res(add_res_v[1]),
    .reg_ra(reg_ra_v[1]), .reg_rw(reg_rw_v[1]), .reg_we(reg_we_v[1]), .mem_we(mem_we_v[1]),
    .done(done_v[1]), .err(err_v[1])
  );

  // somador models: 6-bit result, subtract wraps.
  assign add_res_v[0] = add_sinal_v[0] ? ({1'b0, add_a_v[0]} - {1'b0, add_b_v[0]})
                                       : ({1'b0, add_a_v[0]} + {1'b0, add_b_v[0]});
  assign add_res_v[1] = add_sinal_v[1] ? ({1'b0, add_a_v[1]} - {1'b0, add_b_v[1]})
                                       : ({1'b0, add_a_v[1]} + {1'b0, add_b_v[1]});

  // registrador / memoria models: doutA -> din on mem_we, dout -> Rw on reg_we.
  always @(posedge clk) begin
    if (mem_we_v[0]) mem0[add_res_v[0]] <= rf0[reg_ra_v[0]];
    if (reg_we_v[0]) rf0[reg_rw_v[0]]   <= mem0[add_res_v[0]];
  end

  always @(posedge clk) begin
    if (mem_we_v[1]) mem1[add_res_v[1]] <= rf1[reg_ra_v[1]];
    if (reg_we_v[1]) rf1[reg_rw_v[1]]   <= mem1[add_res_v[1]];
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one command on instance u and trace it until done (bounded).
  // Called at posedge+1 with the instance idle; returns at posedge+1 in IDLE.
  task automatic run_cmd(input int u, input logic op, input logic [4:0] a,
                         input logic [4:0] b, input logic sub, input logic [4:0] r);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_sub = sub; cmd_reg = r;
    cmd_valid[u] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[u] = 1'b0;
    first_mem = -1; cnt_mem = 0; first_reg = -1; cnt_reg = 0;
    done_cyc = -1; err_val = -1; busy = 0;
    ra_at_we = -1; rw_at_we = -1; res_at_we = -1;
    for (int k = 1; k <= 16; k++) begin
      if (mem_we_v[u]) begin
        if (first_mem < 0) begin
          first_mem = k; ra_at_we = int'(reg_ra_v[u]); res_at_we = int'(add_res_v[u]);
        end
        cnt_mem++;
      end
      if (reg_we_v[u]) begin
        if (first_reg < 0) begin
          first_reg = k; rw_at_we = int'(reg_rw_v[u]);
        end
        cnt_reg++;
      end
      if (!cmd_ready_v[u]) busy++;
      if (done_v[u]) begin
        done_cyc = k; err_val = int'(err_v[u]);
      end
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ready_cyc, done1, done2;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(cmd_ready_v[0]), 1);
    check("rst_done", int'(done_v[0]), 0);
    check("rst_we", int'({mem_we_v[0], reg_we_v[0]}), 0);
    check("rst_err", int'(err_v[0]), 0);
    check("rst_add_a", int'(add_a_v[0]), 0);
    check("rst_reg_ra", int'(reg_ra_v[0]), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store reg[0]=32 to address 0+7.
    run_cmd(0, 1'b1, 5'd0, 5'd7, 1'b0, 5'd0);
    check("st_busy", busy, 3);
    check("st_mem_cyc", first_mem, 2);
    check("st_mem_cnt", cnt_mem, 1);
    check("st_reg_cnt", cnt_reg, 0);
    check("st_addr", res_at_we, 7);
    check("st_done", done_cyc, 3);
    check("st_err", err_val, 0);
    check("st_mem7", int'(mem0[7]), 32);
    check("st_ready_after", int'(cmd_ready_v[0]), 1);

    // Load address 7 into reg 12, READ_LAT=1.
    run_cmd(0, 1'b0, 5'd0, 5'd7, 1'b0, 5'd12);
    check("ld_reg_cyc", first_reg, 3);
    check("ld_reg_cnt", cnt_reg, 1);
    check("ld_rw", rw_at_we, 12);
    check("ld_mem_cnt", cnt_mem, 0);
    check("ld_done", done_cyc, 4);
    check("ld_err", err_val, 0);
    check("ld_rf12", int'(rf0[12]), 32);

    // Subtract underflow 3-5 wraps to 62: must still fault.
    run_cmd(0, 1'b1, 5'd3, 5'd5, 1'b1, 5'd0);
    check("uf_done", done_cyc, 2);
    check("uf_err", err_val, 1);
    check("uf_mem_cnt", cnt_mem, 0);
    check("uf_reg_cnt", cnt_reg, 0);
    check("uf_mem62", int'(mem0[62]), 0);

    // 31+31 = 62 is legal.
    run_cmd(0, 1'b1, 5'd31, 5'd31, 1'b0, 5'd5);
    check("max_err", err_val, 0);
    check("max_mem62", int'(mem0[62]), 77);

    // a-b with a=b gives address 0, legal.
    run_cmd(0, 1'b1, 5'd9, 5'd9, 1'b1, 5'd5);
    check("zero_err", err_val, 0);
    check("zero_mem_cnt", cnt_mem, 1);
    check("zero_mem0", int'(mem0[0]), 77);

    // Back-to-back: store 2+3 from reg5, then load 1+4 into reg9 with valid held.
    cmd_op = 1'b1; cmd_a = 5'd2; cmd_b = 5'd3; cmd_sub = 1'b0; cmd_reg = 5'd5;
    cmd_valid[0] = 1'b1;
    @(posedge clk); #1;
    cmd_op = 1'b0; cmd_a = 5'd1; cmd_b = 5'd4; cmd_reg = 5'd9;
    ready_cyc = -1; done1 = -1; done2 = -1; first_mem = -1; first_reg = -1;
    ra_at_we = -1; rw_at_we = -1;
    for (int k = 1; k <= 20; k++) begin
      if (mem_we_v[0] && first_mem < 0) begin
        first_mem = k; ra_at_we = int'(reg_ra_v[0]);
      end
      if (reg_we_v[0] && first_reg < 0) begin
        first_reg = k; rw_at_we = int'(reg_rw_v[0]);
      end
      if (done_v[0]) begin
        if (done1 < 0) done1 = k;
        else if (done2 < 0) done2 = k;
      end
      if (cmd_ready_v[0] && ready_cyc < 0) ready_cyc = k;
      @(posedge clk); #1;
      if (ready_cyc >= 0) cmd_valid[0] = 1'b0;
      if (done2 >= 0) break;
    end
    cmd_valid[0] = 1'b0;
    check("b2b_mem_cyc", first_mem, 2);
    check("b2b_ra", ra_at_we, 5);
    check("b2b_done1", done1, 3);
    check("b2b_ready", ready_cyc, 4);
    check("b2b_reg_cyc", first_reg, 7);
    check("b2b_rw", rw_at_we, 9);
    check("b2b_done2", done2, 8);
    check("b2b_mem5", int'(mem0[5]), 77);
    check("b2b_rf9", int'(rf0[9]), 77);

    // MEM_DEPTH=40: 20+25=45 faults, 20+19=39 is legal.
    run_cmd(1, 1'b1, 5'd20, 5'd25, 1'b0, 5'd5);
    check("rng_hi_done", done_cyc, 2);
    check("rng_hi_err", err_val, 1);
    check("rng_hi_mem_cnt", cnt_mem, 0);
    check("rng_hi_mem45", int'(mem1[45]), 0);
    run_cmd(1, 1'b1, 5'd20, 5'd19, 1'b0, 5'd5);
    check("rng_ok_done", done_cyc, 3);
    check("rng_ok_err", err_val, 0);
    check("rng_ok_mem39", int'(mem1[39]), 55);

    // Load with READ_LAT=3.
    run_cmd(1, 1'b0, 5'd20, 5'd19, 1'b0, 5'd12);
    check("ld3_reg_cyc", first_reg, 5);
    check("ld3_done", done_cyc, 6);
    check("ld3_rf12", int'(rf1[12]), 55);

    // Reset pulse during RD_WAIT aborts the load.
    cmd_op = 1'b0; cmd_a = 5'd20; cmd_b = 5'd19; cmd_sub = 1'b1; cmd_reg = 5'd14;
    cmd_sub = 1'b0;
    cmd_valid[1] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    @(posedge clk); #1;
    check("ab_busy", int'(cmd_ready_v[1]), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("ab_ready", int'(cmd_ready_v[1]), 1);
    check("ab_strobes", int'({reg_we_v[1], mem_we_v[1], done_v[1], err_v[1]}), 0);
    check("ab_add", int'({add_a_v[1], add_b_v[1], add_sinal_v[1]}), 0);
    check("ab_regs", int'({reg_ra_v[1], reg_rw_v[1]}), 0);
    cnt_reg = 0; cnt_mem = 0; done_cyc = 0;
    for (int k = 0; k < 10; k++) begin
      if (reg_we_v[1]) cnt_reg++;
      if (mem_we_v[1]) cnt_mem++;
      if (done_v[1]) done_cyc++;
      @(posedge clk); #1;
    end
    check("ab_reg_we", cnt_reg, 0);
    check("ab_mem_we", cnt_mem, 0);
    check("ab_done", done_cyc, 0);
    check("ab_rf14", int'(rf1[14]), 17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ldst_sequencer.md
Name: ldst_sequencer

Overview:
- Hardware initiator for the load/store datapath made of `somador`, `registrador` and `memoria`.
- Accepts one load or store command per handshake. Drives the adder operands, the register-file ports and the memory write enable in the correct cycle order, so software/bench no longer toggles `weReg` and `weMem` by hand.
- Sits between the instruction decode stage and the three datapath blocks.
- Its outputs connect directly to those blocks' `a`, `b`, `sinal`, `Ra`, `Rw`, `we` inputs. The adder result `soma` is fed back for range checking.

Parameters:
- `READ_LAT`, 1, cycles from a stable memory address to valid `memoria.dout`. Legal range 1..7.
- `MEM_DEPTH`, 64, number of valid memory words. Addresses >= `MEM_DEPTH` are errors.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  1  0 = load (mem -> reg), 1 = store (reg -> mem).
- `cmd_a`  in  5  adder operand a (base).
- `cmd_b`  in  5  adder operand b (offset).
- `cmd_sub`  in  1  adder mode: 0 = a+b, 1 = a-b.
- `cmd_reg`  in  5  register index: store source, load destination.
- `add_a`  out  5  to `somador.a`.
- `add_b`  out  5  to `somador.b`.
- `add_sinal`  out  1  to `somador.sinal`.
- `add_res`  in  6  from `somador.soma`, used for the range check.
- `reg_ra`  out  5  to `registrador.Ra`.
- `reg_rw`  out  5  to `registrador.Rw`.
- `reg_we`  out  1  to `registrador.we`.
- `mem_we`  out  1  to `memoria.we`.
- `done`  out  1  one-cycle pulse at command completion.
- `err`  out  1  valid with `done`. 1 = address fault, no write performed.

Behaviour:
- Reset: synchronous, active-low, sampled at the rising edge of `clk`.
  - All outputs go to 0, except `cmd_ready`, which goes to 1.
  - State goes to IDLE and the wait counter clears.
  - Reset asserted mid-command aborts it: no `reg_we` or `mem_we` pulse after the reset edge, and no `done`.
- Handshake: a command is accepted on the edge where `cmd_valid && cmd_ready`.
  - `cmd_ready` = 1 only in IDLE.
  - All `cmd_*` fields are latched at acceptance. Later changes are ignored until the next accept.
- `add_a`, `add_b`, `add_sinal`, `reg_ra` and `reg_rw` hold the latched values from acceptance until return to IDLE. They keep their last values in IDLE.
- States:
  - IDLE: wait for the handshake, then go to ADDR.
  - ADDR (1 cycle): the adder settles. `add_res` is sampled at the end of this cycle.
    - Fault if `cmd_sub` = 1 and `a` < `b` (underflow).
    - Fault if `add_res` >= `MEM_DEPTH`.
    - Fault -> go to DONE with `err` = 1.
    - Otherwise store -> go to MEM_WR; load -> go to RD_WAIT.
  - MEM_WR (1 cycle): `mem_we` = 1 and `reg_ra` = `cmd_reg`, so `doutA` feeds `memoria.din`. Then go to DONE.
  - RD_WAIT: a 3-bit counter counts `READ_LAT` cycles. `mem_we` = 0. Then go to REG_WR.
  - REG_WR (1 cycle): `reg_we` = 1 and `reg_rw` = `cmd_reg`. Then go to DONE.
  - DONE (1 cycle): `done` = 1, `err` per the ADDR check. Then go to IDLE.
- `mem_we` and `reg_we` are never both 1. Each is high for exactly one cycle per successful command.
- Latency from acceptance edge to `done` high:
  - store: 3 cycles.
  - load: 3 + `READ_LAT` cycles.
  - fault: 2 cycles.
- Back-to-back: a new command can be accepted on the first IDLE cycle after DONE. Minimum issue interval is 4 cycles (store).
- A command held on `cmd_valid` during busy is not accepted until `cmd_ready` returns.
- Boundary results:
  - `add_res` = 63 with `MEM_DEPTH` = 64 is legal.
  - a = b with subtract gives address 0, legal.
  - a = 31, b = 31 add gives 62, legal.

Test Plan:
- Reset, then store with a=0, b=7, sub=0, reg=0 (reg[0]=32) -> `cmd_ready` 0 for 3 cycles; `mem_we` high exactly in cycle 2; `add_res`=7; `done`=1, `err`=0 in cycle 3; mem[7]=32.
- Load with a=0, b=7, reg=12, then read Ra=12 -> `reg_we` high one cycle in cycle 2+`READ_LAT` with `reg_rw`=12; `done` in cycle 3+`READ_LAT`; `doutA`=32.
- Subtract underflow: a=3, b=5, sub=1, store -> `done`=1, `err`=1 at cycle 2; `mem_we` and `reg_we` never asserted.
- Range, with `MEM_DEPTH`=40: a=20, b=25 (sum 45) -> `err`=1 and no write. Then a=20, b=19 (sum 39) -> `err`=0 and the write occurs.
- Back-to-back: store then load issued with `cmd_valid` held high -> second command accepted on the first IDLE cycle after `done`; load returns the just-stored value; `cmd_*` changes during busy have no effect.
- Reset pulse (`rst_n`=0 for 1 cycle) during RD_WAIT of a load with `READ_LAT`=3 -> no `reg_we` and no `done`; `cmd_ready`=1 and all other outputs 0 after the reset edge; the target register is unchanged.
